addr4u_redundant_sched: RTL and testbench

// - Shares one external combinational unsigned 4-bit adder among 2**ID_W requesters.
// - Arbitration is round-robin.
// - Fault resilience through time redundancy: each operation runs twice, the second time with operands swapped.

---
 rtl/addr4u_redundant_sched.sv | 122 ++++++++++++
 tb/tb_addr4u_redundant_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/addr4u_redundant_sched.sv
// addr4u_redundant_sched: round-robin sharing of one 4-bit adder with swapped-operand double execution and retry
module addr4u_redundant_sched #(
  parameter int ID_W = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2**ID_W-1:0]     req_valid,
  input  logic [4*2**ID_W-1:0]   req_a,
  input  logic [4*2**ID_W-1:0]   req_b,
  output logic [2**ID_W-1:0]     req_ready,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  input  logic [4:0]             add_sum,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [4:0]             rsp_sum,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [CNT_W-1:0]       mis_cnt
);
  localparam int N_REQ = 2**ID_W;
  localparam logic [3:0] MAXR = 4'(MAX_RETRY);
  localparam logic [2:0] IDLE = 3'd0, RUN1 = 3'd1, RUN2 = 3'd2, CHECK = 3'd3, RESP = 3'd4;
  logic [2:0] state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, grant, idx;
  logic [3:0] retry_q, retry_d, a_q, a_d, b_q, b_d;
  logic [4:0] sum1_q, sum1_d, sum2_q, sum2_d;
  logic err_q, err_d, found;
  logic [CNT_W-1:0] mis_q, mis_d;
  // descending scan so the candidate closest to the pointer is written last and wins
  always_comb begin
    grant = rr_q;
    idx = rr_q;
    found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = rr_q + ID_W'(k);
      if (req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    id_d = id_q;
    retry_d = retry_q;
    a_d = a_q;
    b_d = b_q;
    sum1_d = sum1_q;
    sum2_d = sum2_q;
    err_d = err_q;
    mis_d = mis_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = RUN1;
        id_d = grant;
        a_d = req_a[4*grant +: 4];
        b_d = req_b[4*grant +: 4];
        retry_d = 4'd0;
        err_d = 1'b0;
      end
      RUN1: begin
        sum1_d = add_sum;
        state_d = RUN2;
      end
      RUN2: begin
        sum2_d = add_sum;
        state_d = CHECK;
      end
      CHECK: if (sum1_q == sum2_q) state_d = RESP;
      else begin
        mis_d = &mis_q ? mis_q : mis_q + 1'b1;
        state_d = retry_q < MAXR ? RUN1 : RESP;
        retry_d = retry_q < MAXR ? retry_q + 4'd1 : retry_q;
        err_d = retry_q >= MAXR;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rr_d = id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      retry_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum1_q <= '0;
      sum2_q <= '0;
      err_q <= 1'b0;
      mis_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      retry_q <= retry_d;
      a_q <= a_d;
      b_q <= b_d;
      sum1_q <= sum1_d;
      sum2_q <= sum2_d;
      err_q <= err_d;
      mis_q <= mis_d;
    end
  end
  assign busy = state_q != IDLE;
  assign req_ready = (state_q == IDLE && found) ? N_REQ'(1) << grant : '0;
  assign add_a = state_q == RUN1 ? a_q : state_q == RUN2 ? b_q : 4'd0;
  assign add_b = state_q == RUN1 ? b_q : state_q == RUN2 ? a_q : 4'd0;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = rsp_valid ? id_q : '0;
  assign rsp_sum = rsp_valid ? sum1_q : '0;
  assign rsp_err = rsp_valid & err_q;
  assign mis_cnt = mis_q;
endmodule

// File: tb/tb_addr4u_redundant_sched.sv
// tb_addr4u_redundant_sched: scoreboard bench with a fault-injecting adder model and a transaction-level reference
module tb_addr4u_redundant_sched;
  localparam int MAX_RETRY = 2;
  logic clk, rst;
  logic [3:0] req_valid, req_ready, add_a, add_b;
  logic [15:0] req_a, req_b;
  logic [4:0] add_sum, rsp_sum;
  logic rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0] rsp_id;
  logic [7:0] mis_cnt;
  int cyc, n_chk, n_fail, fault_mode, arm_gen, used_gen, drv;
  bit hw_armed, pend;

  typedef struct {
    logic [1:0] id;
    logic [4:0] sum;
    logic err;
    int t;
    int mis;
  } exp_t;
  exp_t q[$];
  bit m_busy, first, late;
  int m_rr, m_mis;

  addr4u_redundant_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_err(rsp_err), .busy(busy), .mis_cnt(mis_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external adder core, with optional stuck (mode 2) or one-shot (mode 1) faults
  always_comb begin
    add_sum = 5'(add_a) + 5'(add_b);
    if (fault_mode == 2 && add_a == 4'hF) add_sum[2] = ~add_sum[2];
    if (fault_mode == 1 && hw_armed && add_a == 4'd5 && add_b == 4'd3) add_sum[0] = ~add_sum[0];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_add(input logic [3:0] x, input logic [3:0] y, input bit tr);
    return (5'(x) + 5'(y)) ^ ((fault_mode == 2 && x == 4'hF) ? 5'd4 : 5'd0) ^ (tr ? 5'd1 : 5'd0);
  endfunction

  // monitor and reference model
  always @(negedge clk) begin
    exp_t e;
    int g, rt;
    bit fnd, tr;
    logic [3:0] ea, eb;
    logic [4:0] s1, s2;
    if (rst) begin
      chk("reset_outputs", 32'({req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_err, busy, mis_cnt}), 32'd0);
      q.delete();
      m_busy = 0; m_rr = 0; m_mis = 0; first = 1; late = 0;
      used_gen = arm_gen;
    end else begin
      chk("busy", 32'(busy), 32'(m_busy));
      fnd = 0; g = 0;
      if (!m_busy)
        for (int k = 0; k < 4; k++)
          if (!fnd && req_valid[(m_rr + k) % 4]) begin g = (m_rr + k) % 4; fnd = 1; end
      if (fnd) begin
        chk("req_ready_grant", 32'(req_ready), 32'(1 << g));
        ea = req_a[4*g +: 4];
        eb = req_b[4*g +: 4];
        e.err = 0; rt = 0; s1 = 0;
        for (int p = 0; p <= MAX_RETRY; p++) begin
          s1 = ref_add(ea, eb, 0);
          tr = fault_mode == 1 && arm_gen != used_gen && eb == 4'd5 && ea == 4'd3;
          if (tr) used_gen = arm_gen;
          s2 = ref_add(eb, ea, tr);
          rt = p;
          if (s1 == s2) break;
          if (m_mis < 255) m_mis++;
          if (p == MAX_RETRY) e.err = 1;
        end
        e.id = 2'(g); e.sum = s1; e.t = cyc + 4 + 3 * rt; e.mis = m_mis;
        q.push_back(e);
        m_busy = 1;
      end else chk("req_ready_idle", 32'(req_ready), 32'd0);
      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          e = q[0];
          if (first) chk("rsp_latency", 32'(cyc), 32'(e.t));
          first = 0;
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("mis_cnt", 32'(mis_cnt), 32'(e.mis));
          if (rsp_ready) begin
            void'(q.pop_front());
            m_busy = 0; m_rr = (e.id + 1) % 4; first = 1; late = 0;
          end
        end
      end else if (q.size() > 0 && cyc > q[0].t && !late) begin
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        late = 1;
      end
    end
  end

  // one cycle of stimulus: retire granted requests, then refill per driver mode
  task automatic step();
    logic [3:0] gr;
    @(negedge clk);
    gr = req_ready;
    if (fault_mode == 1 && add_a == 4'd5 && add_b == 4'd3) pend = 1;
    else if (pend) begin hw_armed = 0; pend = 0; end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (gr[i]) begin
        if (drv == 2) begin
          req_a[4*i +: 4] = 4'($urandom);
          req_b[4*i +: 4] = 4'($urandom);
        end else req_valid[i] = 0;
      end
      if (drv == 1 && !req_valid[i] && $urandom_range(2) == 0) begin
        req_valid[i] = 1;
        req_a[4*i +: 4] = 4'($urandom);
        req_b[4*i +: 4] = 4'($urandom);
      end
    end
    if (drv == 1) rsp_ready = $urandom_range(3) != 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic req(input int i, input logic [3:0] a, input logic [3:0] b);
    req_valid[i] = 1;
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 1;
    fault_mode = 0; arm_gen = 0; hw_armed = 0; pend = 0; drv = 0;
    steps(3);
    rst = 0;
    steps(2);
    req(0, 4'd9, 4'd7);
    steps(8);
    drv = 2;
    for (int i = 0; i < 4; i++) req(i, 4'($urandom), 4'($urandom));
    steps(26);
    drv = 0; req_valid = 0;
    steps(8);
    fault_mode = 1; hw_armed = 1; arm_gen++;
    req(0, 4'd3, 4'd5);
    steps(11);
    fault_mode = 0; hw_armed = 0;
    fault_mode = 2;
    req(0, 4'hF, 4'd1);
    steps(14);
    fault_mode = 0;
    rsp_ready = 0;
    req(1, 4'd2, 4'd6);
    steps(3);
    req(2, 4'hA, 4'hB);
    steps(7);
    rsp_ready = 1;
    steps(12);
    req(3, 4'd7, 4'd8);
    steps(2);
    #2 rst = 1;
    steps(2);
    rst = 0;
    req(3, 4'd4, 4'd4);
    steps(10);
    drv = 1;
    steps(600);
    drv = 0; req_valid = 0; rsp_ready = 1;
    steps(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
